// File: rtl/pipeline_stage_receiver.sv
// Two-entry elastic skid buffer at the input of a downstream pipeline stage.
// Optional saturating stall counter enabled by defining PIPELINE_STALL_COUNT_EN.
module pipeline_stage_receiver #(
  parameter int NUM_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_BYTES*8-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_BYTES*8-1:0] out_data,
  input  logic                   flush,
  output logic [1:0]             occupancy
`ifdef PIPELINE_STALL_COUNT_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  localparam int W = NUM_BYTES * 8;

  // Encoding equals the entry count so occupancy is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           accept;
  logic           consume;

  // Handshake outputs depend only on the state flops, never on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_EMPTY;
      // NOTE: the data registers are reset too because out_data must read
      // zero after reset; flush, by contrast, leaves them stale.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPELINE_STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  assign stall_count = stall_count_q;

  // Saturating: once at all-ones the counter holds. Flush does not clear it.
  always_comb begin
    stall_count_d = stall_count_q;
    if (out_valid && !out_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_receiver.sv
// Self-checking bench for pipeline_stage_receiver: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_pipeline_stage_receiver;

  localparam int NUM_BYTES = 16;
  localparam int W = NUM_BYTES * 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   occupancy;
`ifdef PIPELINE_STALL_COUNT_EN
  logic [31:0]  stall_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: FIFO contents, value shown on out_data, stall cycles.
  logic [W-1:0] mq[$];
  logic [W-1:0] disp;
  longint       m_stall;

  pipeline_stage_receiver #(.NUM_BYTES(NUM_BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPELINE_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, then wait
  // 1 time unit so the caller samples outputs away from the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic r);
    logic acc, con;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      disp    = '0;
      m_stall = 0;
    end else begin
      acc = v && (mq.size() < 2);
      con = ordy && (mq.size() > 0);
      if (mq.size() > 0 && !ordy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (fl) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
      if (mq.size() > 0) disp = mq[0];
    end
    #1;
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset.in_ready got %b exp 1", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset.out_valid got %b exp 0", out_valid);
    end
    n_vec++;
    if (occupancy !== 2'd0) begin
      n_bad++; $display("FAIL reset.occupancy got %0d exp 0", occupancy);
    end
    n_vec++;
    if (out_data !== '0) begin
      n_bad++; $display("FAIL reset.out_data got %0h exp 0", out_data);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        n_bad++;
        $display("FAIL stream.data[%0d] got v=%b %0h exp v=1 %0h", i, out_valid, out_data, i);
      end
      n_vec++;
      if (in_ready !== 1'b1 || occupancy > 2'd1) begin
        n_bad++;
        $display("FAIL stream.flow[%0d] got rdy=%b occ=%0d exp rdy=1 occ<=1", i, in_ready, occupancy);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stream.drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, W'(8'hAA), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(8'hBB), 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp.full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready);
    end
    cycle(1'b1, W'(8'hCC), 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (occupancy !== 2'd2 || out_data !== W'(8'hAA)) begin
      n_bad++; $display("FAIL bp.refuse got occ=%0d %0h exp occ=2 aa", occupancy, out_data);
    end
    cycle(1'b1, W'(8'hCC), 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== W'(8'hBB)) begin
      n_bad++; $display("FAIL bp.second got v=%b %0h exp v=1 bb", out_valid, out_data);
    end
    cycle(1'b1, W'(8'hCC), 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== W'(8'hCC) || occupancy !== 2'd1) begin
      n_bad++;
      $display("FAIL bp.third got v=%b %0h occ=%0d exp v=1 cc occ=1", out_valid, out_data, occupancy);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_bad++; $display("FAIL bp.drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, W'(8'h11), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(8'h22), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(8'h33), 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_bad++;
      $display("FAIL flush.empty got v=%b rdy=%b occ=%0d exp v=0 rdy=1 occ=0", out_valid, in_ready, occupancy);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush.stays_empty got %b exp 0", out_valid);
    end
    cycle(1'b1, W'(8'h66), 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== W'(8'h66) || occupancy !== 2'd1) begin
      n_bad++;
      $display("FAIL flush.next got v=%b %0h occ=%0d exp v=1 66 occ=1", out_valid, out_data, occupancy);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, W'(8'h44), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(8'h55), 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL rst_mid got v=%b occ=%0d %0h exp v=0 occ=0 0", out_valid, occupancy, out_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid.after got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 30) == 0, 1'b0);
      n_vec++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          occupancy !== 2'(mq.size()) || out_data !== disp) begin
        n_bad++;
        $display("FAIL rand[%0d] got v=%b rdy=%b occ=%0d %0h exp v=%b rdy=%b occ=%0d %0h",
                 i, out_valid, in_ready, occupancy, out_data,
                 mq.size() > 0, mq.size() < 2, mq.size(), disp);
      end
`ifdef PIPELINE_STALL_COUNT_EN
      n_vec++;
      if (stall_count !== 32'(m_stall)) begin
        n_bad++; $display("FAIL rand.stall[%0d] got %0d exp %0d", i, stall_count, m_stall);
      end
`endif
    end
  endtask

`ifdef PIPELINE_STALL_COUNT_EN
  task automatic test_stall_count();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, W'(8'h77), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (stall_count !== 32'd5 || stall_count !== 32'(m_stall)) begin
      n_bad++; $display("FAIL stall.count got %0d exp 5", stall_count);
    end
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (stall_count !== 32'd5) begin
      n_bad++; $display("FAIL stall.flush got %0d exp 5", stall_count);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (stall_count !== 32'd0) begin
      n_bad++; $display("FAIL stall.rst got %0d exp 0", stall_count);
    end
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    disp      = '0;
    m_stall   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPELINE_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
